// File: rtl/clkgen_pkg.sv
// Shared types and defaults for the multi-channel clock-pattern generator.
package clkgen_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_RUN  = 2'd1,
      CH_DONE = 2'd2
   } ch_state_t;

   localparam int NUM_CH_DEF = 4;
   localparam int DIV_W_DEF  = 8;
   localparam int CNT_W_DEF  = 16;

   // A half-period of zero would never toggle; it behaves as one cycle.
   function automatic logic [31:0] clamp_half(input logic [31:0] half);
      return (half == '0) ? 32'd1 : half;
   endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One divided-clock channel: config registers, run state, phase and rise counters.
module clkgen_channel
   import clkgen_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_sel,
   input  logic [DIV_W-1:0] cfg_half,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic             en,
   output logic             clk_out,
   output logic             pos_stb,
   output logic             neg_stb,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic             done
);

   ch_state_t        state_q, state_d;
   logic [DIV_W-1:0] phase_q, phase_d;
   logic [DIV_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             pos_q, pos_d;
   logic             neg_q, neg_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      half_d  = half_q;
      limit_d = limit_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      pos_d   = 1'b0;
      neg_d   = 1'b0;
      unique case (state_q)
         CH_IDLE: begin
            if (cfg_sel) begin
               half_d  = DIV_W'(clamp_half(32'(cfg_half)));
               limit_d = cfg_limit;
            end
            if (en) begin
               state_d = CH_RUN;
               phase_d = '0;
               cnt_d   = '0;
            end
         end
         CH_RUN: begin
            // A stop request only takes effect while low, so a high pulse is never cut short.
            if (!en && !clk_q) begin
               state_d = CH_IDLE;
            end else if (phase_q == half_q - DIV_W'(1)) begin
               phase_d = '0;
               clk_d   = !clk_q;
               if (!clk_q) begin
                  pos_d = 1'b1;
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  neg_d = 1'b1;
                  if (!en) begin
                     state_d = CH_IDLE;
                  end else if (limit_q != '0 && cnt_q == limit_q) begin
                     state_d = CH_DONE;
                  end
               end
            end else begin
               phase_d = phase_q + DIV_W'(1);
            end
         end
         CH_DONE: begin
            if (!en) state_d = CH_IDLE;
         end
         default: state_d = CH_IDLE;
      endcase
      done_d = (state_d == CH_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CH_IDLE;
         phase_q <= '0;
         half_q  <= DIV_W'(1);
         limit_q <= '0;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
         pos_q   <= 1'b0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         half_q  <= half_d;
         limit_q <= limit_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
         pos_q   <= pos_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
      end
   end

   assign clk_out = clk_q;
   assign pos_stb = pos_q;
   assign neg_stb = neg_q;
   assign cyc_cnt = cnt_q;
   assign done    = done_q;

endmodule

// File: rtl/clkgen_multi.sv
// NUM_CH independent programmable divided clocks sharing one configuration port.
module clkgen_multi
   import clkgen_pkg::*;
#(
   parameter  int NUM_CH = NUM_CH_DEF,
   parameter  int DIV_W  = DIV_W_DEF,
   parameter  int CNT_W  = CNT_W_DEF,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic [DIV_W-1:0]        cfg_half,
   input  logic [CNT_W-1:0]        cfg_limit,
   input  logic [NUM_CH-1:0]       en,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       pos_stb,
   output logic [NUM_CH-1:0]       neg_stb,
   output logic [NUM_CH*CNT_W-1:0] cyc_cnt,
   output logic [NUM_CH-1:0]       done
);

   // Channel indices beyond NUM_CH-1 match no channel, so such writes are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = cfg_we && (cfg_ch == CH_W'(i));

      clkgen_channel #(
         .DIV_W (DIV_W),
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .cfg_sel   (sel),
         .cfg_half  (cfg_half),
         .cfg_limit (cfg_limit),
         .en        (en[i]),
         .clk_out   (clk_out[i]),
         .pos_stb   (pos_stb[i]),
         .neg_stb   (neg_stb[i]),
         .cyc_cnt   (cyc_cnt[i*CNT_W +: CNT_W]),
         .done      (done[i])
      );
   end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi with an edge-count model checked every cycle.
module tb_clkgen_multi;

   localparam int NCH   = 3;
   localparam int DIV_W = 8;
   localparam int CNT_W = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cfg_we;
   logic [1:0]           cfg_ch;
   logic [DIV_W-1:0]     cfg_half;
   logic [CNT_W-1:0]     cfg_limit;
   logic [NCH-1:0]       en;
   logic [NCH-1:0]       clk_out, pos_stb, neg_stb, done;
   logic [NCH*CNT_W-1:0] cyc_cnt;

   int n_vec = 0;
   int n_bad = 0;

   clkgen_multi #(.NUM_CH(NCH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_half  (cfg_half),
      .cfg_limit (cfg_limit),
      .en        (en),
      .clk_out   (clk_out),
      .pos_stb   (pos_stb),
      .neg_stb   (neg_stb),
      .cyc_cnt   (cyc_cnt),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Model: levels and counts follow from k, the number of edges since the run began.
   int m_state [NCH];
   int m_k     [NCH];
   int m_half  [NCH];
   int m_limit [NCH];
   int m_cnt   [NCH];
   bit m_clk   [NCH];
   bit m_pos   [NCH];
   bit m_neg   [NCH];
   bit m_done  [NCH];

   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         int tog, rises;
         m_pos[c] = 1'b0;
         m_neg[c] = 1'b0;
         if (rst) begin
            m_state[c] = 0; m_k[c] = 0; m_half[c] = 1; m_limit[c] = 0;
            m_cnt[c] = 0; m_clk[c] = 1'b0;
         end else if (m_state[c] == 0) begin
            if (cfg_we && int'(cfg_ch) == c) begin
               m_half[c]  = (cfg_half == 0) ? 1 : int'(cfg_half);
               m_limit[c] = int'(cfg_limit);
            end
            if (en[c]) begin
               m_state[c] = 1; m_k[c] = 0; m_cnt[c] = 0;
            end
         end else if (m_state[c] == 1) begin
            if (!en[c] && !m_clk[c]) begin
               m_state[c] = 0;
            end else begin
               m_k[c]++;
               if (m_k[c] % m_half[c] == 0) begin
                  tog      = m_k[c] / m_half[c];
                  rises    = (tog + 1) / 2;
                  m_clk[c] = (tog % 2) == 1;
                  m_cnt[c] = rises % (1 << CNT_W);
                  if (m_clk[c]) m_pos[c] = 1'b1;
                  else begin
                     m_neg[c] = 1'b1;
                     if (!en[c]) m_state[c] = 0;
                     else if (m_limit[c] != 0 && rises == m_limit[c]) m_state[c] = 2;
                  end
               end
            end
         end else begin
            if (!en[c]) m_state[c] = 0;
         end
         m_done[c] = (m_state[c] == 2);
      end
   end

   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         logic [7:0] act, exp_v;
         act   = {clk_out[c], pos_stb[c], neg_stb[c], done[c], cyc_cnt[c*CNT_W +: CNT_W]};
         exp_v = {m_clk[c], m_pos[c], m_neg[c], m_done[c], CNT_W'(m_cnt[c])};
         n_vec++;
         if (act !== exp_v) begin
            n_bad++;
            $display("FAIL model_ch%0d t=%0t got clk/pos/neg/done/cnt=%b required %b", c, $time, act, exp_v);
         end
      end
   end

   function automatic int cnt_of(int c);
      return int'(cyc_cnt[c*CNT_W +: CNT_W]);
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s got %0d required %0d", name, act, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int npos;
      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_limit = '0; en = '0;
      step(3);
      chk("rst_clk_out", int'(clk_out), 0);
      chk("rst_cyc_cnt", int'(cyc_cnt), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b0;

      // basic run, write and enable in the same cycle
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd1; cfg_limit = 4'd10; en[0] = 1'b1;
      step(1);
      cfg_we = 1'b0;
      chk("basic_t0_clk", int'(clk_out[0]), 0);
      step(19);
      chk("basic_last_pos", int'(pos_stb[0]), 1);
      chk("basic_cnt_at_19", cnt_of(0), 10);
      chk("basic_not_done_19", int'(done[0]), 0);
      step(1);
      chk("basic_done_20", int'(done[0]), 1);
      chk("basic_clk_low_20", int'(clk_out[0]), 0);
      chk("basic_cnt_20", cnt_of(0), 10);
      en[0] = 1'b0;
      step(1);
      chk("basic_done_clear", int'(done[0]), 0);

      // independent channels
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd3; cfg_limit = 4'd0;
      step(1);
      cfg_ch = 2'd2; cfg_half = 8'd5;
      step(1);
      cfg_we = 1'b0; en[1] = 1'b1; en[2] = 1'b1;
      step(1);
      step(60);
      chk("indep_cnt_ch1", cnt_of(1), 10);
      chk("indep_cnt_ch2", cnt_of(2), 6);
      chk("indep_no_done", int'(done), 0);

      // stop while low, then stop mid-high with half=4
      en[1] = 1'b0;
      step(3);
      chk("stop_low_hold", cnt_of(1), 10);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd4; cfg_limit = 4'd0;
      step(1);
      cfg_we = 1'b0; en[1] = 1'b1;
      step(1);
      step(5);
      chk("stophi_high_5", int'(clk_out[1]), 1);
      en[1] = 1'b0;
      step(2);
      chk("stophi_still_high_7", int'(clk_out[1]), 1);
      step(1);
      chk("stophi_low_8", int'(clk_out[1]), 0);
      chk("stophi_neg_8", int'(neg_stb[1]), 1);
      chk("stophi_cnt_8", cnt_of(1), 1);
      step(4);
      chk("stophi_idle_clk", int'(clk_out[1]), 0);
      chk("stophi_idle_cnt", cnt_of(1), 1);

      // write to a running channel is ignored
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd1; cfg_limit = 4'd1;
      step(1);
      cfg_we = 1'b0;
      npos = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         npos += int'(pos_stb[2]);
      end
      chk("runwrite_pos_in_20", npos, 2);
      chk("runwrite_no_done", int'(done[2]), 0);

      // half=0 behaves as 1; limit 15 is loaded but not reached before reset
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd0; cfg_limit = 4'd15;
      step(1);
      cfg_we = 1'b0; en[0] = 1'b1;
      step(1);
      step(1);
      chk("half0_t1", int'(clk_out[0]), 1);
      step(1);
      chk("half0_t2", int'(clk_out[0]), 0);
      step(1);
      chk("half0_t3", int'(clk_out[0]), 1);

      // out-of-range channel write leaves ch1 at half=4
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd7; cfg_limit = 4'd5;
      step(1);
      cfg_we = 1'b0; en[1] = 1'b1;
      step(1);
      step(3);
      chk("badch_t3_low", int'(clk_out[1]), 0);
      step(1);
      chk("badch_t4_high", int'(clk_out[1]), 1);

      // reset at cycle 7 of the ch1 run
      step(2);
      rst = 1'b1;
      step(1);
      chk("midrst_clk_out", int'(clk_out), 0);
      chk("midrst_pos", int'(pos_stb), 0);
      chk("midrst_neg", int'(neg_stb), 0);
      chk("midrst_cnt", int'(cyc_cnt), 0);
      chk("midrst_done", int'(done), 0);
      rst = 1'b0; en = 3'b001;
      step(1);
      step(1);
      chk("rerun_t1", int'(clk_out[0]), 1);
      step(1);
      chk("rerun_t2", int'(clk_out[0]), 0);

      // 18 rises with a 4-bit counter and reset limit 0
      step(33);
      chk("wrap_pos_35", int'(pos_stb[0]), 1);
      chk("wrap_cnt_35", cnt_of(0), 2);
      chk("wrap_no_done", int'(done[0]), 0);

      en = '0;
      step(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
